// File: rtl/aes_stream_pkg.sv
// ---------------------------------------------------------------------------
// aes_stream_pkg
// Shared definitions for the AES stream adapters that sit between the AES
// core and the HWPE streamer (block packer / block unstacker).
//   AES_BLOCK_W   : width of one AES block (default block width parameter)
//   AES_WORD_W    : width of one streamer word (default word width parameter)
//   unstk_state_e : state encoding of the block unstacker
// ---------------------------------------------------------------------------
package aes_stream_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;

  typedef enum logic {
    UNSTK_IDLE,
    UNSTK_EMIT
  } unstk_state_e;

endpackage

// File: rtl/block_unstacker_if.sv
// ---------------------------------------------------------------------------
// block_unstacker_if
// Bundles both handshake sides of the block unstacker.
//   valid_i / ready_o / block_i : incoming 128-bit block stream
//   valid_o / ready_i / word_o  : outgoing 32-bit word stream
//   last_o                      : marks the final word of each block
// Modports:
//   slave  : unstacker side (consumes blocks, produces words)
//   master : environment side (produces blocks, consumes words)
// ---------------------------------------------------------------------------
interface block_unstacker_if
  import aes_stream_pkg::*;
#(
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int WORD_W  = AES_WORD_W
) ();

  logic               valid_i;
  logic               ready_o;
  logic [BLOCK_W-1:0] block_i;
  logic               valid_o;
  logic               ready_i;
  logic [WORD_W-1:0]  word_o;
  logic               last_o;

  modport slave (
    input  valid_i, block_i, ready_i,
    output ready_o, valid_o, word_o, last_o
  );

  modport master (
    output valid_i, block_i, ready_i,
    input  ready_o, valid_o, word_o, last_o
  );

endinterface

// File: rtl/block_unstacker.sv
// ---------------------------------------------------------------------------
// block_unstacker
// Splits each 128-bit AES result block into a stream of 32-bit words, MSB
// word first, for the HWPE streamer sink. Inverse of the word-to-block packer.
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   clr_i    : synchronous clear, returns to the reset state (beats enable_i)
//   enable_i : global enable, low freezes all state and blocks handshakes
//   bus      : block_unstacker_if.slave (block in, word out, last_o)
// Configuration:
//   BLOCK_UNSTACKER_PREFETCH_EN : adds a one-block pending slot so the next
//   block can be taken during emission, giving zero-bubble throughput.
// ---------------------------------------------------------------------------
module block_unstacker
  import aes_stream_pkg::*;
#(
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int WORD_W  = AES_WORD_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              enable_i,
  block_unstacker_if.slave  bus
);

  localparam int NWORDS = BLOCK_W / WORD_W;
  localparam int CNT_W  = $clog2(NWORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  unstk_state_e       state_q, state_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef BLOCK_UNSTACKER_PREFETCH_EN
  logic [BLOCK_W-1:0] pend_q, pend_d;
  logic               pend_v_q, pend_v_d;
`endif

  logic              in_hs;
  logic              out_hs;
  logic              last_word;
  logic [WORD_W-1:0] word_sel;

  // Handshake qualifiers come from registered state only, so there is no
  // combinational path from ready_i back to ready_o.
  assign bus.valid_o = enable_i & (state_q == UNSTK_EMIT);
`ifdef BLOCK_UNSTACKER_PREFETCH_EN
  assign bus.ready_o = enable_i & ~pend_v_q;
`else
  assign bus.ready_o = enable_i & (state_q == UNSTK_IDLE);
`endif

  assign in_hs      = bus.valid_i & bus.ready_o;
  assign out_hs     = bus.valid_o & bus.ready_i;
  assign last_word  = (cnt_q == LAST_CNT);
  assign bus.last_o = bus.valid_o & last_word;

  // Word k sits at the top of the block minus k words; buf_q is zero when no
  // block is held, so word_o naturally reads zero then.
  always_comb begin
    word_sel = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (cnt_q == CNT_W'(k)) word_sel = buf_q[BLOCK_W-1-k*WORD_W -: WORD_W];
    end
  end
  assign bus.word_o = word_sel;

  // Next-state logic. With the pending slot, a block arriving during the last
  // word handshake bypasses pend and goes straight to buf.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
`ifdef BLOCK_UNSTACKER_PREFETCH_EN
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
`endif
    if (clr_i) begin
      state_d = UNSTK_IDLE;
      buf_d   = '0;
      cnt_d   = '0;
`ifdef BLOCK_UNSTACKER_PREFETCH_EN
      pend_d   = '0;
      pend_v_d = 1'b0;
`endif
    end else if (enable_i) begin
      case (state_q)
        UNSTK_IDLE: begin
          if (in_hs) begin
            buf_d   = bus.block_i;
            cnt_d   = '0;
            state_d = UNSTK_EMIT;
          end
        end
        UNSTK_EMIT: begin
`ifdef BLOCK_UNSTACKER_PREFETCH_EN
          if (in_hs) begin
            pend_d   = bus.block_i;
            pend_v_d = 1'b1;
          end
`endif
          if (out_hs) begin
            if (!last_word) begin
              cnt_d = cnt_q + 1'b1;
            end else begin
              cnt_d = '0;
`ifdef BLOCK_UNSTACKER_PREFETCH_EN
              if (pend_v_q) begin
                buf_d    = pend_q;
                pend_v_d = 1'b0;
              end else if (in_hs) begin
                buf_d    = bus.block_i;
                pend_v_d = 1'b0;
              end else begin
                buf_d   = '0;
                state_d = UNSTK_IDLE;
              end
`else
              buf_d   = '0;
              state_d = UNSTK_IDLE;
`endif
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= UNSTK_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
`ifdef BLOCK_UNSTACKER_PREFETCH_EN
      pend_q   <= '0;
      pend_v_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
`ifdef BLOCK_UNSTACKER_PREFETCH_EN
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
`endif
    end
  end

endmodule

// File: tb/tb_block_unstacker.sv
// ---------------------------------------------------------------------------
// tb_block_unstacker
// Self-checking bench for block_unstacker. A reference model keeps the words
// still owed to the consumer in a queue: an accepted block appends its words
// MSB-first, a word handshake pops the front. Outputs are derived from the
// queue occupancy. Honours BLOCK_UNSTACKER_PREFETCH_EN like the design.
// ---------------------------------------------------------------------------
module tb_block_unstacker;
  import aes_stream_pkg::*;

  localparam int BLOCK_W = AES_BLOCK_W;
  localparam int WORD_W  = AES_WORD_W;
  localparam int NWORDS  = BLOCK_W / WORD_W;
  localparam int TOTW    = WORD_W + 3;
`ifdef BLOCK_UNSTACKER_PREFETCH_EN
  localparam int EXP_B2B = 2 * NWORDS;
`else
  localparam int EXP_B2B = 2 * NWORDS + 1;
`endif
  localparam logic [BLOCK_W-1:0] BLK = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic clk_i    = 1'b0;
  logic rst_ni   = 1'b0;
  logic clr_i    = 1'b0;
  logic enable_i = 1'b1;

  int checks = 0;
  int passed = 0;

  logic [WORD_W-1:0] expQ[$];
  logic [WORD_W-1:0] refW[4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
  logic [TOTW-1:0]   actVec;
  bit                mdlIn, mdlOut;

  block_unstacker_if #(.BLOCK_W(BLOCK_W), .WORD_W(WORD_W)) bus ();

  block_unstacker #(.BLOCK_W(BLOCK_W), .WORD_W(WORD_W)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clr_i),
    .enable_i (enable_i),
    .bus      (bus)
  );

  always #5 clk_i = ~clk_i;

  assign actVec = {bus.valid_o, bus.ready_o, bus.last_o, bus.word_o};

  // Reference expectations, all derived from how many words are still owed.
  function automatic bit expValid();
    return enable_i && (expQ.size() > 0);
  endfunction

  function automatic bit expReady();
`ifdef BLOCK_UNSTACKER_PREFETCH_EN
    return enable_i && (expQ.size() <= NWORDS);
`else
    return enable_i && (expQ.size() == 0);
`endif
  endfunction

  function automatic bit expLast();
    return expValid() && ((expQ.size() % NWORDS) == 1);
  endfunction

  function automatic logic [WORD_W-1:0] expWord();
    return (expQ.size() > 0) ? expQ[0] : '0;
  endfunction

  function automatic logic [TOTW-1:0] expVec();
    return {expValid(), expReady(), expLast(), expWord()};
  endfunction

  function automatic logic [BLOCK_W-1:0] randBlock();
    logic [BLOCK_W-1:0] b;
    for (int i = 0; i < BLOCK_W / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Model update: evaluated with pre-edge inputs and queue contents.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      expQ.delete();
    end else if (clr_i) begin
      expQ.delete();
    end else if (enable_i) begin
      mdlIn  = bus.valid_i && expReady();
      mdlOut = bus.ready_i && expValid();
      if (mdlOut) void'(expQ.pop_front());
      if (mdlIn) begin
        for (int k = 0; k < NWORDS; k++)
          expQ.push_back(bus.block_i[BLOCK_W-1-k*WORD_W -: WORD_W]);
      end
    end
  end

  // Reset values, with enable_i both high and low.
  task automatic test_reset();
    rst_ni = 1'b0; clr_i = 1'b0; enable_i = 1'b1;
    bus.valid_i = 1'b0; bus.ready_i = 1'b0; bus.block_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (actVec !== {1'b0, 1'b1, 1'b0, {WORD_W{1'b0}}})
      $display("[TB] FAIL reset_en1: actual %h expected %h", actVec, {1'b0, 1'b1, 1'b0, {WORD_W{1'b0}}});
    else passed++;
    enable_i = 1'b0;
    #1;
    checks++;
    if (actVec !== {TOTW{1'b0}})
      $display("[TB] FAIL reset_en0: actual %h expected %h", actVec, {TOTW{1'b0}});
    else passed++;
    enable_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if (actVec !== expVec())
      $display("[TB] FAIL reset_release: actual %h expected %h", actVec, expVec());
    else passed++;
  endtask

  // One block drained at full speed against the known word sequence.
  task automatic test_single_block();
    bus.block_i = BLK; bus.valid_i = 1'b1; bus.ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.valid_i = 1'b0; bus.block_i = randBlock();
    for (int i = 0; i < NWORDS; i++) begin
      @(negedge clk_i);
      checks++;
      if (actVec !== {1'b1, 1'b0, (i == NWORDS - 1), refW[i]})
        $display("[TB] FAIL single_word%0d: actual %h expected %h", i, actVec,
                 {1'b1, 1'b0, (i == NWORDS - 1), refW[i]});
      else passed++;
      @(posedge clk_i);
      #1;
    end
    @(negedge clk_i);
    checks++;
    if (actVec !== {1'b0, 1'b1, 1'b0, {WORD_W{1'b0}}})
      $display("[TB] FAIL single_idle: actual %h expected %h", actVec, {1'b0, 1'b1, 1'b0, {WORD_W{1'b0}}});
    else passed++;
    @(posedge clk_i);
    #1;
  endtask

  // ready_i low for three cycles while word 1 is offered.
  task automatic test_backpressure();
    for (int cyc = 0; cyc <= 8; cyc++) begin
      bus.valid_i = (cyc == 0);
      bus.block_i = (cyc == 0) ? BLK : randBlock();
      bus.ready_i = !(cyc >= 2 && cyc <= 4);
      @(negedge clk_i);
      checks++;
      if (actVec !== expVec())
        $display("[TB] FAIL backpressure_cyc%0d: actual %h expected %h", cyc, actVec, expVec());
      else passed++;
      if (cyc >= 2 && cyc <= 5) begin
        checks++;
        if ({bus.valid_o, bus.word_o} !== {1'b1, refW[1]})
          $display("[TB] FAIL backpressure_hold%0d: actual %h expected %h", cyc,
                   {bus.valid_o, bus.word_o}, {1'b1, refW[1]});
        else passed++;
      end
      @(posedge clk_i);
      #1;
    end
  endtask

  // enable_i low for five cycles after word 1 has been taken.
  task automatic test_enable_hold();
    bus.ready_i = 1'b1;
    for (int cyc = 0; cyc <= 10; cyc++) begin
      enable_i    = !(cyc >= 3 && cyc <= 7);
      bus.valid_i = (cyc == 0) || !enable_i;
      bus.block_i = (cyc == 0) ? BLK : randBlock();
      @(negedge clk_i);
      checks++;
      if (actVec !== expVec())
        $display("[TB] FAIL enable_cyc%0d: actual %h expected %h", cyc, actVec, expVec());
      else passed++;
      if (!enable_i) begin
        checks++;
        if ({bus.valid_o, bus.ready_o} !== 2'b00)
          $display("[TB] FAIL enable_frozen%0d: actual %b expected 00", cyc, {bus.valid_o, bus.ready_o});
        else passed++;
      end
      if (cyc == 8) begin
        checks++;
        if ({bus.valid_o, bus.word_o} !== {1'b1, refW[2]})
          $display("[TB] FAIL enable_resume: actual %h expected %h", {bus.valid_o, bus.word_o}, {1'b1, refW[2]});
        else passed++;
      end
      @(posedge clk_i);
      #1;
    end
    enable_i = 1'b1;
  endtask

  // Clear after word 0, then a fresh block must start at its word 0.
  task automatic test_clear();
    logic [BLOCK_W-1:0] nb;
    nb = randBlock();
    bus.ready_i = 1'b1;
    for (int cyc = 0; cyc <= 8; cyc++) begin
      clr_i       = (cyc == 2);
      bus.valid_i = (cyc == 0) || (cyc == 2) || (cyc == 3);
      bus.block_i = (cyc == 3) ? nb : ((cyc == 0) ? BLK : randBlock());
      @(negedge clk_i);
      checks++;
      if (actVec !== expVec())
        $display("[TB] FAIL clear_cyc%0d: actual %h expected %h", cyc, actVec, expVec());
      else passed++;
      if (cyc == 3) begin
        checks++;
        if (actVec !== {1'b0, 1'b1, 1'b0, {WORD_W{1'b0}}})
          $display("[TB] FAIL clear_state: actual %h expected %h", actVec, {1'b0, 1'b1, 1'b0, {WORD_W{1'b0}}});
        else passed++;
      end
      if (cyc == 4) begin
        checks++;
        if (bus.word_o !== nb[BLOCK_W-1 -: WORD_W])
          $display("[TB] FAIL clear_restart: actual %h expected %h", bus.word_o, nb[BLOCK_W-1 -: WORD_W]);
        else passed++;
      end
      @(posedge clk_i);
      #1;
    end
    clr_i = 1'b0;
    bus.valid_i = 1'b0;
  endtask

  // Two blocks offered back to back with the consumer always ready.
  task automatic test_back_to_back();
    logic [BLOCK_W-1:0] blks[2];
    int  blkIdx   = 0;
    int  hsCount  = 0;
    int  firstCyc = -1;
    int  lastCyc  = -1;
    bit  acc;
    blks[0] = randBlock();
    blks[1] = randBlock();
    bus.ready_i = 1'b1;
    for (int cyc = 0; cyc < 40 && hsCount < 2 * NWORDS; cyc++) begin
      bus.valid_i = (blkIdx < 2);
      if (blkIdx < 2) bus.block_i = blks[blkIdx];
      @(negedge clk_i);
      checks++;
      if (actVec !== expVec())
        $display("[TB] FAIL b2b_cyc%0d: actual %h expected %h", cyc, actVec, expVec());
      else passed++;
      if (bus.valid_o && bus.ready_i) begin
        if (firstCyc < 0) firstCyc = cyc;
        lastCyc = cyc;
        hsCount++;
      end
      acc = bus.valid_i && expReady();
      @(posedge clk_i);
      #1;
      if (acc) blkIdx++;
    end
    bus.valid_i = 1'b0;
    checks++;
    if (hsCount != 2 * NWORDS || (lastCyc - firstCyc + 1) != EXP_B2B)
      $display("[TB] FAIL b2b_throughput: actual %0d words in %0d cycles expected %0d words in %0d cycles",
               hsCount, lastCyc - firstCyc + 1, 2 * NWORDS, EXP_B2B);
    else passed++;
    repeat (NWORDS + 2) @(posedge clk_i);
    #1;
  endtask

  // Reset asserted between clock edges in the middle of a block.
  task automatic test_async_reset();
    bus.block_i = randBlock(); bus.valid_i = 1'b1; bus.ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (actVec !== expVec())
      $display("[TB] FAIL areset_pre: actual %h expected %h", actVec, expVec());
    else passed++;
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (actVec !== {1'b0, 1'b1, 1'b0, {WORD_W{1'b0}}})
      $display("[TB] FAIL areset_async: actual %h expected %h", actVec, {1'b0, 1'b1, 1'b0, {WORD_W{1'b0}}});
    else passed++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    checks++;
    if (actVec !== {1'b0, 1'b1, 1'b0, {WORD_W{1'b0}}})
      $display("[TB] FAIL areset_idle: actual %h expected %h", actVec, {1'b0, 1'b1, 1'b0, {WORD_W{1'b0}}});
    else passed++;
    @(posedge clk_i);
    #1;
  endtask

  // Random traffic, enables and occasional clears, then a clean drain.
  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.valid_i = ($urandom % 4) != 0;
      bus.ready_i = ($urandom % 4) != 0;
      bus.block_i = randBlock();
      enable_i    = ($urandom % 8) != 0;
      clr_i       = ($urandom % 50) == 0;
      @(negedge clk_i);
      checks++;
      if (actVec !== expVec())
        $display("[TB] FAIL random_cyc%0d: actual %h expected %h", cyc, actVec, expVec());
      else passed++;
      @(posedge clk_i);
      #1;
    end
    enable_i = 1'b1; clr_i = 1'b0; bus.valid_i = 1'b0; bus.ready_i = 1'b1;
    for (int cyc = 0; cyc < 2 * NWORDS + 2; cyc++) begin
      @(negedge clk_i);
      checks++;
      if (actVec !== expVec())
        $display("[TB] FAIL drain_cyc%0d: actual %h expected %h", cyc, actVec, expVec());
      else passed++;
      @(posedge clk_i);
      #1;
    end
    checks++;
    if (actVec !== {1'b0, 1'b1, 1'b0, {WORD_W{1'b0}}})
      $display("[TB] FAIL drain_idle: actual %h expected %h", actVec, {1'b0, 1'b1, 1'b0, {WORD_W{1'b0}}});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_enable_hold();
    test_clear();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
